// File: rtl/cache_fill_arbiter_if.sv
// cache_fill_arbiter_if
//   Groups the cache-request, memory-port and fill-steering signals of the
//   shared main-memory port.
//   master : the arbiter (drives mem_*, fill_*, *_fill_we, *_done, ack, busy)
//   slave  : the cache controllers and the memory model
//   Cache side : icache_miss/icache_addr, dcache_miss/dcache_addr,
//                dcache_wr_req/dcache_wr_addr/dcache_wr_data, dcache_wr_ack,
//                icache/dcache_fill_we, icache/dcache_fill_done,
//                fill_data, fill_word, busy
//   Memory side: mem_en, mem_wr, mem_addr, mem_wdata,
//                mem_data_valid, mem_rdata
interface cache_fill_arbiter_if;
  logic        icache_miss;
  logic [15:0] icache_addr;
  logic        dcache_miss;
  logic [15:0] dcache_addr;
  logic        dcache_wr_req;
  logic [15:0] dcache_wr_addr;
  logic [15:0] dcache_wr_data;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_data_valid;
  logic [15:0] mem_rdata;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        icache_fill_we;
  logic        dcache_fill_we;
  logic        icache_fill_done;
  logic        dcache_fill_done;
  logic        dcache_wr_ack;
  logic        busy;

  modport master (
    input  icache_miss, icache_addr, dcache_miss, dcache_addr,
           dcache_wr_req, dcache_wr_addr, dcache_wr_data,
           mem_data_valid, mem_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata,
           fill_data, fill_word, icache_fill_we, dcache_fill_we,
           icache_fill_done, dcache_fill_done, dcache_wr_ack, busy
  );

  modport slave (
    output icache_miss, icache_addr, dcache_miss, dcache_addr,
           dcache_wr_req, dcache_wr_addr, dcache_wr_data,
           mem_data_valid, mem_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
           fill_data, fill_word, icache_fill_we, dcache_fill_we,
           icache_fill_done, dcache_fill_done, dcache_wr_ack, busy
  );
endinterface

// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter
//   Shares one main-memory port between the I-cache and D-cache. Grants one
//   requester at a time (store > D miss > I miss), issues the WORDS reads of
//   a block fill or a single write-through store, counts returned words and
//   steers them into the granted cache with per-word write enables.
//   Ports:
//     clk   : system clock, all state on the rising edge
//     rst_n : asynchronous active-low reset
//     bus   : cache_fill_arbiter_if.master (cache requests, memory port,
//             fill steering, done/ack pulses, busy)
//   MEM_LAT describes the attached memory model; returns are tracked purely
//   by mem_data_valid, so the arbiter itself is latency-agnostic.
module cache_fill_arbiter #(
  parameter int unsigned MEM_LAT = 4,
  parameter int unsigned WORDS   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_fill_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, WRITE, FILL} state_e;

  localparam int unsigned      CNT_W    = $clog2(WORDS);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(WORDS - 1);
  localparam logic [15:0]      BLK_MASK = ~16'(2 * WORDS - 1);

  state_e           state_q, state_d;
  logic             dside_q, dside_d;
  logic [15:0]      base_q, base_d;
  logic [CNT_W-1:0] iss_cnt_q, iss_cnt_d;
  logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
  logic             mem_en_q, mem_en_d;
  logic             mem_wr_q, mem_wr_d;
  logic [15:0]      mem_addr_q, mem_addr_d;
  logic [15:0]      mem_wdata_q, mem_wdata_d;
  logic             wr_ack_q, wr_ack_d;
  logic             busy_q, busy_d;
  logic             ret_take;
  logic             ret_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dside_q     <= 1'b0;
      base_q      <= '0;
      iss_cnt_q   <= '0;
      ret_cnt_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_ack_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dside_q     <= dside_d;
      base_q      <= base_d;
      iss_cnt_q   <= iss_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wr_ack_q    <= wr_ack_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dside_d     = dside_q;
    base_d      = base_q;
    iss_cnt_d   = iss_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_ack_d    = 1'b0;

    // Returns only count while filling; strays in IDLE/WRITE are dropped.
    ret_take = (state_q == FILL) && bus.mem_data_valid;
    ret_last = ret_take && (ret_cnt_q == LAST);

    case (state_q)
      IDLE: begin
        if (bus.dcache_wr_req) begin
          state_d     = WRITE;
          mem_en_d    = 1'b1;
          mem_wr_d    = 1'b1;
          mem_addr_d  = bus.dcache_wr_addr;
          mem_wdata_d = bus.dcache_wr_data;
          wr_ack_d    = 1'b1;
        end else if (bus.dcache_miss || bus.icache_miss) begin
          state_d    = FILL;
          dside_d    = bus.dcache_miss;
          base_d     = (bus.dcache_miss ? bus.dcache_addr : bus.icache_addr) & BLK_MASK;
          iss_cnt_d  = '0;
          ret_cnt_d  = '0;
          mem_en_d   = 1'b1;
          mem_addr_d = base_d;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      FILL: begin
        // Registered strobe: word n+1 is set up while word n is on the port.
        if (mem_en_q && (iss_cnt_q != LAST)) begin
          iss_cnt_d  = iss_cnt_q + 1'b1;
          mem_en_d   = 1'b1;
          mem_addr_d = base_q + {{(15 - CNT_W){1'b0}}, iss_cnt_d, 1'b0};
        end
        if (ret_take) begin
          ret_cnt_d = ret_cnt_q + 1'b1;
          if (ret_last) begin
            state_d   = IDLE;
            ret_cnt_d = '0;
            iss_cnt_d = '0;
            mem_en_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.mem_en           = mem_en_q;
  assign bus.mem_wr           = mem_wr_q;
  assign bus.mem_addr         = mem_addr_q;
  assign bus.mem_wdata        = mem_wdata_q;
  assign bus.dcache_wr_ack    = wr_ack_q;
  assign bus.busy             = busy_q;
  assign bus.fill_data        = (state_q == FILL) ? bus.mem_rdata : '0;
  assign bus.fill_word        = ret_cnt_q;
  assign bus.icache_fill_we   = ret_take && !dside_q;
  assign bus.dcache_fill_we   = ret_take && dside_q;
  assign bus.icache_fill_done = ret_last && !dside_q;
  assign bus.dcache_fill_done = ret_last && dside_q;

endmodule

// File: doc/cache_fill_arbiter.md
# cache_fill_arbiter

Sequences the single shared main-memory port between the instruction cache and the data cache of the 16-bit pipelined processor. It grants one requester at a time, issues the eight word reads of a 16-byte block fill (or a single write-through store), counts returned words, and steers them into the granted cache with per-word write enables. It sits between the two cache controllers and the multi-cycle memory model; the pipeline stalls on `busy` and on outstanding misses.

## Interface
- `MEM_LAT`, 4, cycles from a read issue (`mem_en`=1, `mem_wr`=0) to its `mem_data_valid`
- `WORDS`, 8, words per cache block (fixed 16-bit words, 16-byte block)
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `icache_miss`  in  1  I-cache fill request; held until `icache_fill_done`
- `icache_addr`  in  16  missing I-fetch byte address
- `dcache_miss`  in  1  D-cache fill request; held until `dcache_fill_done`
- `dcache_addr`  in  16  missing data byte address
- `dcache_wr_req`  in  1  write-through store request; held until `dcache_wr_ack`
- `dcache_wr_addr`  in  16  store byte address
- `dcache_wr_data`  in  16  store data
- `mem_en`  out  1  memory access strobe, one access per cycle
- `mem_wr`  out  1  1 = write, 0 = read
- `mem_addr`  out  16  memory byte address
- `mem_wdata`  out  16  write data
- `mem_data_valid`  in  1  read data returned this cycle
- `mem_rdata`  in  16  returned read data
- `fill_data`  out  16  word being written into a cache (`mem_rdata` passthrough)
- `fill_word`  out  3  word index within block for `fill_data`
- `icache_fill_we`  out  1  write `fill_data` into I-cache block word
- `dcache_fill_we`  out  1  write `fill_data` into D-cache block word
- `icache_fill_done`  out  1  one-cycle pulse, I block complete
- `dcache_fill_done`  out  1  one-cycle pulse, D block complete
- `dcache_wr_ack`  out  1  one-cycle pulse, store performed
- `busy`  out  1  state is not IDLE

## Operation
- States: IDLE, WRITE, FILL. Reset → IDLE.
- IDLE arbitration, fixed priority: `dcache_wr_req` > `dcache_miss` > `icache_miss` (older instruction wins). Grant latches requester and address; request inputs ignored until return to IDLE.
- WRITE: one cycle; `mem_en`=1, `mem_wr`=1, `mem_addr`/`mem_wdata` = latched store; `dcache_wr_ack`=1; → IDLE.
- FILL: base = latched addr & 16'hFFF0. Issue counter 0..7 drives `mem_en`=1, `mem_wr`=0, `mem_addr` = base + 2×count on consecutive cycles; after count 7, `mem_en`=0. Return counter 0..7 increments on each `mem_data_valid`; `fill_word` = return counter; `fill_data` = `mem_rdata`; matching `*_fill_we` = `mem_data_valid`. On 8th return: `*_fill_done` pulse in same cycle, → IDLE.
- Critical-word-first not supported; words return in order 0..7.
- `mem_data_valid` in IDLE or WRITE ignored: no we, no counter change.
- Request dropped mid-fill: fill still completes and pulses done.
- Reset mid-operation: immediate return to IDLE, counters 0, late returns ignored.
- Reset values: all outputs 0, `mem_addr`/`mem_wdata`/`fill_word` 0.

## Timing
- Request sampled high in IDLE at cycle 0 → state change at edge; first `mem_en` in cycle 1.
- Fill: issues cycles 1–8; returns cycles 1+MEM_LAT..8+MEM_LAT; done pulse cycle 8+MEM_LAT; IDLE cycle 9+MEM_LAT (13 cycles to IDLE at MEM_LAT=4).
- Write: `mem_en`/`dcache_wr_ack` in cycle 1; IDLE cycle 2.
- Back-to-back: one IDLE cycle between grants; pending requests re-arbitrated there.
- `busy` high from cycle 1 through last non-IDLE cycle.
- `fill_*` outputs combinational from `mem_data_valid`/`mem_rdata` and registered state; all others registered.

## Test plan
- I miss at 0x1236 alone, MEM_LAT=4 → reads 0x1230..0x123E cycles 1–8, `icache_fill_we` cycles 5–12 with `fill_word` 0..7, `icache_fill_done` cycle 12, `busy` low cycle 13.
- `icache_miss` and `dcache_miss` (0x4008) asserted same cycle → D fill first (0x4000..0x400E), `dcache_fill_done`, one IDLE cycle, then I fill.
- `dcache_wr_req` 0x2002/0xBEEF with `dcache_miss` pending → write cycle 1 (`mem_wr`=1, ack), IDLE cycle 2, D fill starts cycle 3.
- Spurious `mem_data_valid` in IDLE → no we, no done, counters unchanged; subsequent fill still writes 8 words.
- `rst_n` low during fill word 3 return → all outputs 0 asynchronously, later returns ignored, fresh I miss completes normally.
- `icache_miss` deasserted after cycle 2 of fill → all 8 words written and `icache_fill_done` still pulses.
